// File: rtl/dmem_dump_if.sv
// Bus bundle between the dump controller, the CPU data port, the data memory
// and the word-stream consumer. master = controller side, slave = environment.
interface dmem_dump_if #(
    parameter int IDX_W = 5
);
    logic [31:0]      cpu_daddr;
    logic [31:0]      cpu_dwdata;
    logic [3:0]       cpu_dwe;
    logic [31:0]      cpu_drdata;
    logic             cpu_halt;
    logic [31:0]      mem_daddr;
    logic [31:0]      mem_dwdata;
    logic [3:0]       mem_dwe;
    logic [31:0]      mem_drdata;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_index;

    modport master (
        input  cpu_daddr, cpu_dwdata, cpu_dwe, mem_drdata, out_ready,
        output cpu_drdata, cpu_halt, mem_daddr, mem_dwdata, mem_dwe,
               out_valid, out_data, out_index
    );

    modport slave (
        output cpu_daddr, cpu_dwdata, cpu_dwe, mem_drdata, out_ready,
        input  cpu_drdata, cpu_halt, mem_daddr, mem_dwdata, mem_dwe,
               out_valid, out_data, out_index
    );
endinterface

// File: rtl/dmem_dump_ctrl.sv
// Data-memory dump sequencer: halts the CPU, borrows the dmem port, reads
// NWORDS consecutive words from a base address and streams them out.
module dmem_dump_ctrl #(
    parameter int NWORDS = 32,
    parameter int IDX_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        base_addr,
    dmem_dump_if.master        bus,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HALT = 3'd1,
        ST_READ = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [31:0]      base_r;
    logic [31:0]      out_data_r;
    logic             halt_r;
    logic             valid_r;
    logic             busy_r;
    logic             done_r;
    logic [31:0]      idx_ext_s;
    logic [31:0]      read_addr_s;

    // Word address of the current read; wraps naturally at 2**32.
    always_comb begin
        idx_ext_s   = 32'(idx_r);
        read_addr_s = base_r + (idx_ext_s << 2'd2);
    end

    // Dump sequencer; every output flag is registered alongside the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            base_r     <= 32'd0;
            out_data_r <= 32'd0;
            halt_r     <= 1'b0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        state_r <= ST_HALT;
                        base_r  <= base_addr & 32'hFFFF_FFFC;
                        idx_r   <= '0;
                        halt_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        halt_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
                ST_HALT: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        idx_r   <= '0;
                        halt_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        idx_r   <= '0;
                        halt_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        out_data_r <= bus.mem_drdata;
                        valid_r    <= 1'b1;
                        state_r    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        idx_r   <= '0;
                        halt_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                    end else if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r   <= idx_r + IDX_ONE;
                            state_r <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                ST_DONE: begin
                    // abort here lands in the same place as normal completion
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                    halt_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                    halt_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Port ownership: CPU passes through only in IDLE; writes are blocked otherwise.
    always_comb begin
        bus.mem_daddr  = bus.cpu_daddr;
        bus.mem_dwdata = bus.cpu_dwdata;
        bus.mem_dwe    = bus.cpu_dwe;
        case (state_r)
            ST_IDLE: begin
                bus.mem_daddr  = bus.cpu_daddr;
                bus.mem_dwdata = bus.cpu_dwdata;
                bus.mem_dwe    = bus.cpu_dwe;
            end
            ST_READ: begin
                bus.mem_daddr  = read_addr_s;
                bus.mem_dwdata = 32'd0;
                bus.mem_dwe    = 4'd0;
            end
            default: begin
                bus.mem_daddr  = bus.cpu_daddr;
                bus.mem_dwdata = 32'd0;
                bus.mem_dwe    = 4'd0;
            end
        endcase
    end

    assign bus.cpu_drdata = bus.mem_drdata;
    assign bus.cpu_halt   = halt_r;
    assign bus.out_valid  = valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_index  = idx_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Scoreboard bench for dmem_dump_ctrl: a 64-word model memory on the main
// instance plus a 4-word instance whose memory returns its own address.
module tb_dmem_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        busy, done;
    logic        start4 = 1'b0;
    logic [31:0] base4 = 32'd0;
    logic        busy4, done4;

    dmem_dump_if #(.IDX_W(5)) bus ();
    dmem_dump_if #(.IDX_W(2)) bus4 ();

    dmem_dump_ctrl #(.NWORDS(32), .IDX_W(5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .bus(bus), .busy(busy), .done(done)
    );

    dmem_dump_ctrl #(.NWORDS(4), .IDX_W(2)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .abort(1'b0),
        .base_addr(base4), .bus(bus4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Main data memory: preloaded with 3*i during reset, byte writes otherwise.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(3 * i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_dwe[b]) mem[bus.mem_daddr[7:2]][8*b +: 8] <= bus.mem_dwdata[8*b +: 8];
        end
    end
    assign bus.mem_drdata  = mem[bus.mem_daddr[7:2]];
    assign bus4.mem_drdata = bus4.mem_daddr;
    assign bus4.cpu_daddr  = 32'h1234_5670;
    assign bus4.cpu_dwdata = 32'h0;
    assign bus4.cpu_dwe    = 4'h0;
    assign bus4.out_ready  = 1'b1;

    typedef struct {
        logic [31:0] data;
        logic [31:0] idx;
    } beat_t;
    beat_t exp_q[$];
    beat_t exp4_q[$];
    beat_t mon_b, mon4_b;
    logic        ovr = 1'b0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d, hold_i;

    function automatic logic [31:0] expw(input int i);
        return (ovr && i == 16) ? 32'hCAFE_0000 : 32'(3 * i);
    endfunction

    // Output monitor: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_b = exp_q.pop_front();
                    check_eq("beat_data", bus.out_data, mon_b.data);
                    check_eq("beat_index", 32'(bus.out_index), mon_b.idx);
                end
            end
            if (busy) check_eq("dwe_while_busy", 32'(bus.mem_dwe), 32'd0);
            if (hold_v && bus.out_valid) begin
                check_eq("hold_data", bus.out_data, hold_d);
                check_eq("hold_index", 32'(bus.out_index), hold_i);
            end
            hold_v = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data;
            hold_i = 32'(bus.out_index);
            if (bus4.out_valid) begin
                check_eq("sb4_nonempty", 32'(exp4_q.size() != 0), 32'd1);
                if (exp4_q.size() != 0) begin
                    mon4_b = exp4_q.pop_front();
                    check_eq("beat4_data", bus4.out_data, mon4_b.data);
                    check_eq("beat4_index", 32'(bus4.out_index), mon4_b.idx);
                end
            end
        end
    end

    task automatic run_dump(input logic [31:0] base, input int stall_idx, input int stall_n, input int delay);
        int c0;
        int stalls;
        bit got_done;
        for (int i = 0; i < 32; i++) exp_q.push_back('{expw(i), 32'(i)});
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; bus.out_ready = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("halt_in_halt", 32'(bus.cpu_halt), 32'd1);
        check_eq("busy_in_halt", 32'(busy), 32'd1);
        check_eq("daddr_in_halt", bus.mem_daddr, bus.cpu_daddr);
        got_done = 1'b0;
        stalls = stall_n;
        for (int k = 0; k < 300 && !got_done; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (bus.out_valid && 32'(bus.out_index) == 32'(stall_idx) && stalls > 0) begin
                bus.out_ready = 1'b0;
                stalls--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (done) begin
                got_done = 1'b1;
                check_eq("done_cycle", 32'(cyc), 32'(c0 + 66 + delay));
            end
        end
        check_eq("done_seen", 32'(got_done), 32'd1);
        @(posedge clk); #1;
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("halt_after", 32'(bus.cpu_halt), 32'd0);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int c0;
        bit found;
        bus.cpu_daddr  = 32'h0000_0080;
        bus.cpu_dwdata = 32'h0;
        bus.cpu_dwe    = 4'h0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_halt", 32'(bus.cpu_halt), 32'd0);
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_out_data", bus.out_data, 32'd0);
        check_eq("rst_out_index", 32'(bus.out_index), 32'd0);
        check_eq("rst_passthru_addr", bus.mem_daddr, 32'h0000_0080);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("drdata_passthru", bus.cpu_drdata, 32'd96);

        // Test 1: plain dump
        run_dump(32'h0000_0000, -1, 0, 0);

        // Test 2: 5 cycles of backpressure on index 4
        run_dump(32'h0000_0003, 4, 5, 5);

        // start together with abort in IDLE does nothing
        @(posedge clk); #1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        check_eq("start_abort_idle", 32'(busy), 32'd0);

        // Test 3: CPU keeps writing; passes only in IDLE
        bus.cpu_daddr = 32'h0000_0040; bus.cpu_dwdata = 32'hCAFE_0000; bus.cpu_dwe = 4'hF;
        #1;
        check_eq("idle_dwe_pass", 32'(bus.mem_dwe), 32'hF);
        check_eq("idle_dwdata_pass", bus.mem_dwdata, 32'hCAFE_0000);
        @(posedge clk); #1;
        check_eq("idle_write_landed", mem[16], 32'hCAFE_0000);
        ovr = 1'b1;
        run_dump(32'h0000_0000, -1, 0, 0);
        bus.cpu_dwe = 4'h0; bus.cpu_daddr = 32'h0000_0080;

        // Test 4: address wrap on the 4-word instance (memory echoes address)
        exp4_q.push_back('{32'hFFFF_FFF8, 32'd0});
        exp4_q.push_back('{32'hFFFF_FFFC, 32'd1});
        exp4_q.push_back('{32'h0000_0000, 32'd2});
        exp4_q.push_back('{32'h0000_0004, 32'd3});
        @(posedge clk); #1; start4 = 1'b1; base4 = 32'hFFFF_FFFB; c0 = cyc;
        @(posedge clk); #1; start4 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (done4) begin
                found = 1'b1;
                check_eq("done4_cycle", 32'(cyc), 32'(c0 + 10));
            end
            @(posedge clk); #1;
        end
        check_eq("done4_seen", 32'(found), 32'd1);
        check_eq("sb4_drained", 32'(exp4_q.size()), 32'd0);

        // Test 5: abort while index 10 is presented
        for (int i = 0; i < 10; i++) exp_q.push_back('{expw(i), 32'(i)});
        @(posedge clk); #1; start = 1'b1; base_addr = 32'd0; bus.out_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (bus.out_valid && bus.out_index == 5'd10) begin
                found = 1'b1;
                abort = 1'b1;
                bus.out_ready = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        check_eq("abort_point_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0; bus.out_ready = 1'b1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_halt", 32'(bus.cpu_halt), 32'd0);
        check_eq("abort_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_index", 32'(bus.out_index), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check_eq("no_done_after_abort", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        check_eq("abort_sb_drained", 32'(exp_q.size()), 32'd0);
        run_dump(32'h0000_0000, -1, 0, 0);

        // Test 6: asynchronous reset in the middle of READ
        @(posedge clk); #1; start = 1'b1; base_addr = 32'd0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check_eq("halt_before_rst", 32'(bus.cpu_halt), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_halt", 32'(bus.cpu_halt), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("async_rst_done", 32'(done), 32'd0);
        #2 reset = 1'b0;
        hold_v = 1'b0;
        run_dump(32'h0000_0000, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
